// File: rtl/reg_wb_arb_pkg.sv
// Shared register-file bus widths and constants for the writeback arbiter.
package reg_wb_arb_pkg;
    localparam int          REG_ADDR_W   = 5;
    localparam int          REG_W        = 32;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD = '0;
endpackage

// File: rtl/reg_wb_arb.sv
// Arbitrates the register-file write port between the pipeline WB stage and a
// buffered multi-cycle unit result, forcing a WB bubble if the buffer starves.
import reg_wb_arb_pkg::*;

module reg_wb_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [REG_W-1:0]      wb_wdata,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_waddr,
    input  logic [REG_W-1:0]      mc_wdata,
    output logic                  mc_ready,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata,
    output logic                  stall_req,
    output logic                  pend_valid,
    output logic [REG_ADDR_W-1:0] pend_waddr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    localparam int              CNT_W    = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    state_t                  state;
    logic                    buf_valid;
    logic [REG_ADDR_W-1:0]   buf_addr;
    logic [REG_W-1:0]        buf_data;
    logic [CNT_W-1:0]        cnt;
    logic                    stall_q;

    logic wb_write;
    logic port_free;
    logic drain;
    logic accept;
    logic accept_nz;

    // A pipeline write to r0 is architecturally void, so it leaves the port free.
    assign wb_write  = wb_we && (wb_waddr != ZERO_ADDR);
    assign port_free = !wb_write;
    assign drain     = buf_valid && (port_free || (state == ST_FORCE));
    assign mc_ready  = !buf_valid || drain;
    assign accept    = mc_valid && mc_ready;
    assign accept_nz = accept && (mc_waddr != ZERO_ADDR);

    assign stall_req  = stall_q;
    assign pend_valid = buf_valid;
    assign pend_waddr = buf_addr;

    always_comb begin
        wen   = 1'b0;
        waddr = ZERO_ADDR;
        wdata = ZERO_WORD;
        if (!rst) begin
            if (drain) begin
                wen   = WRITE_ENABLE;
                waddr = buf_addr;
                wdata = buf_data;
            end else if (wb_write) begin
                wen   = WRITE_ENABLE;
                waddr = wb_waddr;
                wdata = wb_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            buf_valid <= 1'b0;
            buf_addr  <= ZERO_ADDR;
            buf_data  <= ZERO_WORD;
            cnt       <= '0;
            stall_q   <= 1'b0;
        end else begin
            // A same-cycle accept refills the slot being drained.
            if (accept_nz) begin
                buf_valid <= 1'b1;
                buf_addr  <= mc_waddr;
                buf_data  <= mc_wdata;
            end else if (drain) begin
                buf_valid <= 1'b0;
                buf_addr  <= ZERO_ADDR;
                buf_data  <= ZERO_WORD;
            end

            case (state)
                ST_IDLE: begin
                    stall_q <= 1'b0;
                    cnt     <= '0;
                    if (accept_nz) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (drain) begin
                        state   <= accept_nz ? ST_WAIT : ST_IDLE;
                        cnt     <= '0;
                        stall_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_FORCE;
                        cnt     <= '0;
                        stall_q <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        stall_q <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    state   <= accept_nz ? ST_WAIT : ST_IDLE;
                    cnt     <= '0;
                    stall_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed bench for reg_wb_arb with hand-computed expectations per cycle.
module tb_reg_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req;
    logic        pend_valid;
    logic [4:0]  pend_waddr;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_writes = 0;

    reg_wb_arb #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .mc_valid  (mc_valid),
        .mc_waddr  (mc_waddr),
        .mc_wdata  (mc_wdata),
        .mc_ready  (mc_ready),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .stall_req (stall_req),
        .pend_valid(pend_valid),
        .pend_waddr(pend_waddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs checked 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic e_wen, input logic [4:0] e_addr,
                            input logic [31:0] e_data);
        chk({tag, "_wen"},   {31'd0, wen},  {31'd0, e_wen});
        chk({tag, "_waddr"}, {27'd0, waddr}, {27'd0, e_addr});
        chk({tag, "_wdata"}, wdata, e_data);
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        cyc(); cyc();
        // Reset state
        chk_port("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_mc_ready", {31'd0, mc_ready},   32'd1);
        chk("rst_stall",    {31'd0, stall_req},  32'd0);
        chk("rst_pend_v",   {31'd0, pend_valid}, 32'd0);
        chk("rst_pend_a",   {27'd0, pend_waddr}, 32'd0);
        rst = 1'b0;
        cyc();

        // Idle port: accept addr 3, write next cycle
        mc_valid = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'h1234;
        #1;
        chk("s1_ready0", {31'd0, mc_ready}, 32'd1);
        chk_port("s1_pre", 1'b0, 5'd0, 32'd0);
        cyc();
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        #1;
        chk_port("s1_wr", 1'b1, 5'd3, 32'h1234);
        chk("s1_ready1", {31'd0, mc_ready}, 32'd1);
        chk("s1_pend_a", {27'd0, pend_waddr}, 32'd3);
        cyc();
        chk_port("s1_post", 1'b0, 5'd0, 32'd0);
        chk("s1_pend_v", {31'd0, pend_valid}, 32'd0);

        // Starvation: pipeline keeps writing r7, buffer holds r5
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hAAAA;
        mc_valid = 1'b1; mc_waddr = 5'd5; mc_wdata = 32'h5555;
        #1;
        chk_port("s2_pipe", 1'b1, 5'd7, 32'hAAAA);
        chk("s2_ready0", {31'd0, mc_ready}, 32'd1);
        cyc();
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("s2_blk%0d_stall", i), {31'd0, stall_req}, 32'd0);
            chk($sformatf("s2_blk%0d_ready", i), {31'd0, mc_ready},  32'd0);
            chk($sformatf("s2_blk%0d_addr", i),  {27'd0, waddr},     32'd7);
            chk($sformatf("s2_blk%0d_pend", i),  {27'd0, pend_waddr}, 32'd5);
            cyc();
        end
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        #1;
        chk("s2_force_stall", {31'd0, stall_req}, 32'd1);
        chk_port("s2_force", 1'b1, 5'd5, 32'h5555);
        chk("s2_force_ready", {31'd0, mc_ready}, 32'd1);
        cyc();
        chk("s2_after_stall", {31'd0, stall_req}, 32'd0);
        chk("s2_after_pend",  {31'd0, pend_valid}, 32'd0);
        chk_port("s2_after", 1'b0, 5'd0, 32'd0);

        // Address 0 accepted and discarded
        mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'hDEAD;
        #1;
        chk("s3_ready", {31'd0, mc_ready}, 32'd1);
        cyc();
        mc_valid = 1'b0; mc_wdata = '0;
        #1;
        chk("s3_pend_v", {31'd0, pend_valid}, 32'd0);
        chk_port("s3", 1'b0, 5'd0, 32'd0);

        // Pipeline write to r0 frees the port for buffered r9
        wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h4444;
        mc_valid = 1'b1; mc_waddr = 5'd9; mc_wdata = 32'h9999;
        cyc();
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        #1;
        chk_port("s4_blk", 1'b1, 5'd4, 32'h4444);
        chk("s4_ready_blk", {31'd0, mc_ready}, 32'd0);
        chk("s4_pend_a", {27'd0, pend_waddr}, 32'd9);
        wb_waddr = 5'd0;
        #1;
        chk_port("s4_drain", 1'b1, 5'd9, 32'h9999);
        chk("s4_ready_drain", {31'd0, mc_ready}, 32'd1);
        cyc();
        wb_we = 1'b0; wb_wdata = '0;
        #1;
        chk("s4_pend_v", {31'd0, pend_valid}, 32'd0);
        chk("s4_stall", {31'd0, stall_req}, 32'd0);

        // Back-to-back accepts on a free port
        mc_valid = 1'b1; mc_waddr = 5'd1; mc_wdata = 32'h11;
        cyc();
        mc_waddr = 5'd2; mc_wdata = 32'h22;
        #1;
        chk_port("s5_w1", 1'b1, 5'd1, 32'h11);
        chk("s5_ready1", {31'd0, mc_ready}, 32'd1);
        cyc();
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        #1;
        chk_port("s5_w2", 1'b1, 5'd2, 32'h22);
        chk("s5_ready2", {31'd0, mc_ready}, 32'd1);
        cyc();
        chk_port("s5_post", 1'b0, 5'd0, 32'd0);

        // Reset while WAIT holds r6 must discard it
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h7777;
        mc_valid = 1'b1; mc_waddr = 5'd6; mc_wdata = 32'h6666;
        cyc();
        mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
        #1;
        chk("s6_pend_v", {31'd0, pend_valid}, 32'd1);
        cyc();
        rst = 1'b1;
        #1;
        chk_port("s6_rst", 1'b0, 5'd0, 32'd0);
        chk("s6_rst_ready", {31'd0, mc_ready},   32'd1);
        chk("s6_rst_stall", {31'd0, stall_req},  32'd0);
        chk("s6_rst_pend_v", {31'd0, pend_valid}, 32'd0);
        chk("s6_rst_pend_a", {27'd0, pend_waddr}, 32'd0);
        cyc();
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("s6_pend_after", {31'd0, pend_valid}, 32'd0);
        chk("s6_no_r6_write", bad_writes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Any write of the discarded r6 result counts against the reset scenario.
    always @(negedge clk) begin
        if (wen === 1'b1 && waddr == 5'd6) bad_writes++;
    end

endmodule
